mips_prog_loader: RTL
=====================

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- BASE_ADDR, 32'hBFC00000, instruction-memory address of the first loaded word.
- MAX_WORDS, 1024, maximum program length in words.
- TIMEOUT_CYCLES, 10000, RUN-phase cycle limit.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- load_valid  in  1  program word present.
- load_ready  out  1  loader accepts a word.
- load_data  in  32  program word.
- load_last  in  1  marks the final word.
- imem_write  out  1  instruction-memory write strobe.
- imem_address  out  32  instruction-memory write address.
- imem_writedata  out  32  instruction-memory write data.
- cpu_reset  out  1  reset to mips_cpu_harvard.
- cpu_clk_enable  out  1  clk_enable to mips_cpu_harvard.
- cpu_active  in  1  active from the CPU.
- cpu_register_v0  in  32  register_v0 from the CPU.
- done  out  1  run finished (halt or timeout).
- result  out  32  captured v0.
- timeout  out  1  run hit TIMEOUT_CYCLES.

Function
REQ-003 The FSM SHALL have exactly these states: LOAD, RELEASE, RUN, FINISH.
REQ-004 In LOAD, load_ready SHALL be 1. A word is accepted on a rising edge where load_valid and load_ready are both 1.
REQ-005 A word accepted at edge k SHALL drive imem_write=1, imem_address=BASE_ADDR+4*n and imem_writedata=load_data for exactly the cycle after edge k. n = 0-based count of previously accepted words. Otherwise imem_write=0.
REQ-006 An accepted word with load_last=1, or the accepted word with n=MAX_WORDS-1, SHALL end loading:
- load_ready=0 from edge k.
- State goes to RELEASE at edge k+1.
- Further load_valid is ignored until reset.
REQ-007 Address arithmetic SHALL be 32-bit modulo 2^32. The word counter SHALL be $clog2(MAX_WORDS)+1 bits wide and SHALL never wrap, because of REQ-006.
REQ-008 RELEASE SHALL last exactly one cycle with cpu_reset=1 and cpu_clk_enable=1. State then goes to RUN.
REQ-009 In RUN:
- cpu_reset=0 and cpu_clk_enable=1.
- The run counter starts at 0 and increments every cycle.
- A seen_active flag sets on the first edge where cpu_active=1.
REQ-010 In RUN, an edge with seen_active=1 and cpu_active=0 SHALL capture cpu_register_v0 into result and go to FINISH with timeout=0.
REQ-011 In RUN, if the run counter reaches TIMEOUT_CYCLES-1 without REQ-010, the next edge SHALL capture cpu_register_v0 and go to FINISH with timeout=1. If REQ-010 and REQ-011 hold on the same edge, REQ-010 SHALL take priority (timeout=0).
REQ-012 In FINISH:
- done=1 and cpu_clk_enable=0.
- cpu_reset=0.
- result and timeout are held.
- FINISH is terminal until reset.
REQ-013 All outputs SHALL be driven from registers; no combinational path SHALL exist from any input to any output.

Reset
REQ-014 Asserting reset SHALL immediately, without waiting for clk, set:
- state=LOAD, word counter=0, run counter=0, seen_active=0.
- load_ready=0, imem_write=0, imem_address=BASE_ADDR, imem_writedata=0.
- cpu_reset=1, cpu_clk_enable=0.
- done=0, result=0, timeout=0.
REQ-015 load_ready SHALL rise on the first rising edge after reset deasserts.
REQ-016 Reset in any state SHALL discard partial loads and run progress; a new program starts again at BASE_ADDR.

Structure
REQ-017 The state enum and the BASE_ADDR default SHALL live in the shared package mips_loader_pkg.
REQ-018 The run counter SHALL be the sub-module loader_timeout_counter, with ports clk, reset, clear, enable, count and expired.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- 3 words (0x24020005, 0x00000000, last 0x00000000) -> imem writes at 0xBFC00000, 0xBFC00004, 0xBFC00008; RELEASE one cycle later.
- load_valid toggled every other cycle -> only handshake edges write; addresses contiguous, no gaps.
- No load_last, MAX_WORDS=4 -> load ends after the 4th word at 0xBFC0000C; the 5th load_valid is not accepted.
- CPU model raises active, then drops it with v0=0x00000005 -> done=1, result=0x00000005, timeout=0, cpu_clk_enable=0.
- TIMEOUT_CYCLES=20, active held high -> done=1 and timeout=1 after 20 RUN cycles. Also: active dropping on the limit edge -> timeout=0.
- reset pulsed mid-LOAD after 2 words -> outputs at reset values at once; the next word writes 0xBFC00000.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared types and defaults for the MIPS program loader.
package mips_loader_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// RUN-phase cycle counter; expired flags count == LIMIT-1.
// Saturates at the limit so it can never wrap.
module loader_timeout_counter #(
  parameter int LIMIT = 10000,
  parameter int WIDTH = $clog2(LIMIT) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             expired
);

  assign expired = (count == WIDTH'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// Streams a program into instruction memory, releases the CPU from reset,
// then waits for it to go idle (or time out) and captures register v0.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int          MAX_WORDS      = 1024,
  parameter int          TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        imem_write,
  output logic [31:0] imem_address,
  output logic [31:0] imem_writedata,
  output logic        cpu_reset,
  output logic        cpu_clk_enable,
  input  logic        cpu_active,
  input  logic [31:0] cpu_register_v0,
  output logic        done,
  output logic [31:0] result,
  output logic        timeout
);

  localparam int WCW = $clog2(MAX_WORDS) + 1;
  localparam int RCW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t           r_state;
  logic [WCW-1:0]   r_word_cnt;
  logic             r_load_end;
  logic             r_seen_active;

  logic             w_accept;
  logic             w_final_word;
  logic             w_halt;
  logic             w_expired;
  logic [RCW-1:0]   w_unused_run_count;

  assign w_accept     = (r_state == LOAD) && load_valid && load_ready;
  assign w_final_word = load_last || (r_word_cnt == WCW'(MAX_WORDS - 1));
  assign w_halt       = r_seen_active && !cpu_active;

  loader_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (RCW)
  ) u_run_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (r_state != RUN),
    .enable  (r_state == RUN),
    .count   (w_unused_run_count),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= LOAD;
      r_word_cnt     <= '0;
      r_load_end     <= 1'b0;
      r_seen_active  <= 1'b0;
      load_ready     <= 1'b0;
      imem_write     <= 1'b0;
      imem_address   <= BASE_ADDR;
      imem_writedata <= '0;
      cpu_reset      <= 1'b1;
      cpu_clk_enable <= 1'b0;
      done           <= 1'b0;
      result         <= '0;
      timeout        <= 1'b0;
    end else begin
      imem_write <= 1'b0;
      case (r_state)
        LOAD: begin
          if (r_load_end) begin
            r_state        <= RELEASE;
            cpu_reset      <= 1'b1;
            cpu_clk_enable <= 1'b1;
          end else if (w_accept) begin
            imem_write     <= 1'b1;
            imem_address   <= word_addr(BASE_ADDR, 32'(r_word_cnt));
            imem_writedata <= load_data;
            r_word_cnt     <= r_word_cnt + WCW'(1);
            if (w_final_word) begin
              r_load_end <= 1'b1;
              load_ready <= 1'b0;
            end
          end else begin
            load_ready <= 1'b1;
          end
        end
        RELEASE: begin
          r_state        <= RUN;
          cpu_reset      <= 1'b0;
          cpu_clk_enable <= 1'b1;
        end
        RUN: begin
          if (cpu_active) r_seen_active <= 1'b1;
          // A genuine halt on the limit edge wins over the timeout.
          if (w_halt || w_expired) begin
            r_state        <= FINISH;
            result         <= cpu_register_v0;
            timeout        <= !w_halt;
            done           <= 1'b1;
            cpu_clk_enable <= 1'b0;
          end
        end
        FINISH: begin
          r_state <= FINISH;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule
